switch_read_ctrl: RTL and testbench

//  Sequences CPU reads of the 16 board switches through a confirm-button handshake.

---
 rtl/switch_read_ctrl_if.sv | 21 ++
 rtl/switch_read_ctrl.sv | 129 ++++++++++++
 tb/tb_switch_read_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/switch_read_ctrl_if.sv
// Switch MMIO window bus: CPU read strobe/address, board pins, and formatted
// read data plus status back to the CPU.
interface switch_read_ctrl_if;
  logic        io_read;
  logic [31:0] address;
  logic [15:0] switch_input;
  logic        confirm_btn;
  logic [15:0] rdata;
  logic        valid;
  logic        busy;

  modport master (
    output io_read, address, switch_input, confirm_btn,
    input  rdata, valid, busy
  );

  modport slave (
    input  io_read, address, switch_input, confirm_btn,
    output rdata, valid, busy
  );
endinterface

// File: rtl/switch_read_ctrl.sv
// Confirm-button read sequencer for the 16 board switches. A debounced press
// snapshots the switches and raises valid; a CPU data read consumes the
// snapshot, and the button must then stay released before the block re-arms.
module switch_read_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input logic               clk,
  input logic               rst,
  switch_read_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ARMED, DEB_PRESS, HOLD, WAIT_RELEASE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0]   snap, snap_nx;
  logic          vld, vld_nx;
  logic          sync1, btn_s;
  logic          data_addr;
  logic          consume;

  // Two-flop synchroniser for the asynchronous confirm button.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= bus.confirm_btn;
      btn_s <= sync1;
    end
  end

  // Data addresses are the ones whose read consumes a pending snapshot.
  always_comb begin
    data_addr = 1'b0;
    case (bus.address)
      32'hFFFF_FFF1, 32'hFFFF_FFF3, 32'hFFFF_FFF5,
      32'hFFFF_FFF7, 32'hFFFF_FFF9: data_addr = 1'b1;
      default:                      data_addr = 1'b0;
    endcase
  end

  assign consume = bus.io_read & vld & data_addr;

  // State, debounce counter, snapshot and valid registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ARMED;
      cnt   <= '0;
      snap  <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      snap  <= snap_nx;
      vld   <= vld_nx;
    end
  end

  // Next-state logic: debounce the press, hold until consumed, then require a
  // stable release so a held button can never trigger a second snapshot.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    snap_nx  = snap;
    vld_nx   = vld;
    case (state)
      ARMED: begin
        if (btn_s) begin
          state_nx = DEB_PRESS;
          cnt_nx   = CW'(1);
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_nx = ARMED;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = HOLD;
          cnt_nx   = '0;
          snap_nx  = bus.switch_input;
          vld_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (consume) begin
          state_nx = WAIT_RELEASE;
          cnt_nx   = '0;
          vld_nx   = 1'b0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx = ARMED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ARMED;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.valid = vld;
  assign bus.busy  = (state == DEB_PRESS) || (state == WAIT_RELEASE);

  // Per-address formatting of the snapshot; the status word never consumes.
  always_comb begin
    bus.rdata = 16'h0000;
    case (bus.address)
      32'hFFFF_FFF1: bus.rdata = snap;
      32'hFFFF_FFF3: bus.rdata = {{8{snap[15]}}, snap[15:8]};
      32'hFFFF_FFF5: bus.rdata = {8'h00, snap[15:8]};
      32'hFFFF_FFF7: bus.rdata = {8'h00, snap[7:0]};
      32'hFFFF_FFF9: bus.rdata = {13'h0, snap[2:0]};
      32'hFFFF_FFFB: bus.rdata = {14'h0, bus.busy, vld};
      default:       bus.rdata = 16'h0000;
    endcase
  end
endmodule

// File: tb/tb_switch_read_ctrl.sv
// Directed bench for switch_read_ctrl with DEBOUNCE_CYCLES=4. Expected read
// data is queued when an address is driven and popped when rdata is sampled.
module tb_switch_read_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_read_ctrl_if bus();

  switch_read_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [15:0] e);
    logic [15:0] ex;
    exp_q.push_back(e);
    bus.address = a;
    #1;
    ex = exp_q.pop_front();
    chk(tag, bus.rdata, ex);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int   n;
    logic busy_seen;

    rst              = 1'b0;
    bus.io_read      = 1'b0;
    bus.address      = 32'h0;
    bus.switch_input = 16'h0;
    bus.confirm_btn  = 1'b0;
    tick();
    tick();

    // Reset state
    rd("rst_fff1", 32'hFFFF_FFF1, 16'h0000);
    rd("rst_fffb", 32'hFFFF_FFFB, 16'h0000);
    chk("rst_valid", 16'(bus.valid), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    rst = 1'b1;
    tick();

    // Short presses must be rejected
    bus.switch_input = 16'h1234;
    busy_seen = 1'b0;
    repeat (2) begin
      bus.confirm_btn = 1'b1;
      repeat (3) begin tick(); busy_seen |= bus.busy; end
      bus.confirm_btn = 1'b0;
      repeat (8) begin tick(); busy_seen |= bus.busy; end
    end
    chk("glitch_busy_seen", 16'(busy_seen), 16'h1);
    chk("glitch_valid", 16'(bus.valid), 16'h0);
    chk("glitch_busy_end", 16'(bus.busy), 16'h0);
    rd("glitch_fff1", 32'hFFFF_FFF1, 16'h0000);

    // Clean press
    bus.switch_input = 16'hA5C3;
    bus.confirm_btn  = 1'b1;
    wait_valid(n);
    chk("press_latency", 16'(n), 16'd6);
    rd("press_fff1", 32'hFFFF_FFF1, 16'hA5C3);
    rd("press_fff3", 32'hFFFF_FFF3, 16'hFFA5);
    rd("press_fff5", 32'hFFFF_FFF5, 16'h00A5);
    rd("press_fff7", 32'hFFFF_FFF7, 16'h00C3);
    rd("press_fff9", 32'hFFFF_FFF9, 16'h0003);

    // Consume with the button still held
    bus.address = 32'hFFFF_FFF7;
    bus.io_read = 1'b1;
    tick();
    bus.io_read = 1'b0;
    chk("consume_valid", 16'(bus.valid), 16'h0);
    rd("held_fffb", 32'hFFFF_FFFB, 16'h0002);
    bus.switch_input = 16'h5555;
    repeat (2) tick();
    rd("held_fff1", 32'hFFFF_FFF1, 16'hA5C3);
    rd("held_fffb2", 32'hFFFF_FFFB, 16'h0002);

    // Release re-arms; data read with valid low changes nothing
    bus.confirm_btn  = 1'b0;
    bus.switch_input = 16'h8001;
    repeat (8) tick();
    rd("rearm_fffb", 32'hFFFF_FFFB, 16'h0000);
    bus.address = 32'hFFFF_FFF1;
    bus.io_read = 1'b1;
    tick();
    bus.io_read = 1'b0;
    rd("stale_fff1", 32'hFFFF_FFF1, 16'hA5C3);
    rd("stale_fffb", 32'hFFFF_FFFB, 16'h0000);

    // Second press
    bus.confirm_btn = 1'b1;
    wait_valid(n);
    chk("press2_latency", 16'(n), 16'd6);
    rd("press2_fff3", 32'hFFFF_FFF3, 16'hFF80);
    rd("press2_fff9", 32'hFFFF_FFF9, 16'h0001);
    repeat (2) tick();
    bus.confirm_btn = 1'b0;

    // Status and unmapped reads never consume
    repeat (3) begin
      bus.io_read = 1'b1;
      rd("status_fffb", 32'hFFFF_FFFB, 16'h0001);
      tick();
    end
    rd("unmapped", 32'h1234_0000, 16'h0000);
    tick();
    bus.io_read = 1'b0;
    chk("status_valid", 16'(bus.valid), 16'h1);
    rd("status_fff1", 32'hFFFF_FFF1, 16'h8001);

    // Reset during HOLD
    rst = 1'b0;
    tick();
    chk("rsthold_valid", 16'(bus.valid), 16'h0);
    chk("rsthold_busy", 16'(bus.busy), 16'h0);
    rd("rsthold_fff1", 32'hFFFF_FFF1, 16'h0000);
    rst = 1'b1;
    tick();

    // Reset during DEB_PRESS
    bus.switch_input = 16'h7777;
    bus.confirm_btn  = 1'b1;
    repeat (4) tick();
    chk("deb_busy", 16'(bus.busy), 16'h1);
    rst = 1'b0;
    tick();
    chk("rstdeb_busy", 16'(bus.busy), 16'h0);
    chk("rstdeb_valid", 16'(bus.valid), 16'h0);
    rd("rstdeb_fff1", 32'hFFFF_FFF1, 16'h0000);
    bus.confirm_btn = 1'b0;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("after_valid", 16'(bus.valid), 16'h0);
    rd("after_fff1", 32'hFFFF_FFF1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
